// File: rtl/chunked_seq_adder_if.sv
// rtl/chunked_seq_adder_if.sv - start/busy/done handshake and operand/result bundle
// The adder takes the slave side; whoever issues operations takes the master side.
interface chunked_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - multi-cycle adder, one CHUNK-bit slice per clock
// Carry is held in a register between slices; results appear only at the done edge.
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst,
  chunked_seq_adder_if.slave  bus
);
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_slice;
  int unsigned      sh;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] slice_mask;

  assign accept     = (state_q == IDLE) && bus.start;
  assign last_slice = (state_q == RUN) && (idx_q == IDXW'(N - 1));

  // Slice adder: selects slice idx of the latched operands by shifting.
  always_comb begin
    sh         = 32'(idx_q) * 32'(CHUNK);
    a_sl       = CHUNK'(a_q >> sh);
    b_sl       = CHUNK'(b_q >> sh);
    slice_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    slice_mask = WIDTH'({CHUNK{1'b1}}) << sh;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_slice) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs, all taken straight from registers
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = done_q;
    bus.s    = s_q;
    bus.cout = cout_q;
    bus.ovf  = ovf_q;
  end

  // Datapath next state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    psum_d  = psum_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      idx_d   = '0;
      psum_d  = '0;
    end else if (state_q == RUN) begin
      psum_d  = (psum_q & ~slice_mask) | (WIDTH'(slice_sum[CHUNK-1:0]) << sh);
      carry_d = slice_sum[CHUNK];
      idx_d   = idx_q + IDXW'(1);
      if (last_slice) begin
        // Overflow judged on the latched operands, not on the live inputs.
        s_d    = psum_d;
        cout_d = slice_sum[CHUNK];
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (psum_d[WIDTH-1] != a_q[WIDTH-1]);
        done_d = 1'b1;
        idx_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      psum_q  <= psum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb/tb_chunked_seq_adder.sv - self-checking bench for chunked_seq_adder
// One 16/4 instance for directed and random work, three 4-bit instances swept exhaustively.
module tb_chunked_seq_adder;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] last_s16;

  always #5 clk = ~clk;

  chunked_seq_adder_if #(.WIDTH(16)) bus16  ();
  chunked_seq_adder_if #(.WIDTH(4))  bus_c1 ();
  chunked_seq_adder_if #(.WIDTH(4))  bus_c2 ();
  chunked_seq_adder_if #(.WIDTH(4))  bus_c4 ();

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  chunked_seq_adder #(.WIDTH(4),  .CHUNK(1)) u_dut_c1 (.clk(clk), .rst(rst), .bus(bus_c1));
  chunked_seq_adder #(.WIDTH(4),  .CHUNK(2)) u_dut_c2 (.clk(clk), .rst(rst), .bus(bus_c2));
  chunked_seq_adder #(.WIDTH(4),  .CHUNK(4)) u_dut_c4 (.clk(clk), .rst(rst), .bus(bus_c4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition; result packed as {cout, s, ovf}.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] full;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    ov   = (a[15] == b[15]) && (full[15] != a[15]);
    return {full[16], full[15:0], ov};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] full;
    logic       ov;
    full = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    ov   = (a[3] == b[3]) && (full[3] != a[3]);
    return {full[4], full[3:0], ov};
  endfunction

  // Issues one op on the 16-bit DUT; optionally pulses start again at cycle 'inject'.
  task automatic run_op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input int inject);
    logic [17:0] exp;
    int          lat;
    bit          held;
    bit          excl;
    bit          seen;
    exp  = model16(a, b, cin);
    held = 1'b1;
    excl = 1'b1;
    seen = 1'b0;
    lat  = 0;
    bus16.start = 1'b1;
    bus16.a     = a;
    bus16.b     = b;
    bus16.cin   = cin;
    while (lat < 10 && !seen) begin
      @(negedge clk);
      lat++;
      if (bus16.done && bus16.busy) excl = 1'b0;
      seen = bus16.done;
      if (!seen && (bus16.s !== last_s16 || bus16.busy !== 1'b1)) held = 1'b0;
      bus16.start = !seen && (lat == inject);
      bus16.a     = (lat == inject) ? 16'hAAAA : 16'($urandom);
      bus16.b     = (lat == inject) ? 16'h5555 : 16'($urandom);
      bus16.cin   = 1'($urandom);
    end
    check({tag, " result"}, 64'({bus16.cout, bus16.s, bus16.ovf}), 64'(exp));
    check({tag, " latency"}, 64'(lat - 1), 64'd4);
    check({tag, " hold/busy"}, 64'(held), 64'd1);
    check({tag, " done!busy"}, 64'(excl), 64'd1);
    last_s16 = exp[16:1];
  endtask

  initial begin
    logic [15:0] qa [30];
    logic [15:0] qb [30];
    logic        qc [30];
    bit          seen;
    int          dones;

    rst = 1'b1;
    bus16.start = 1'b0;  bus16.a = '0;  bus16.b = '0;  bus16.cin = 1'b0;
    bus_c1.start = 1'b0; bus_c1.a = '0; bus_c1.b = '0; bus_c1.cin = 1'b0;
    bus_c2.start = 1'b0; bus_c2.a = '0; bus_c2.b = '0; bus_c2.cin = 1'b0;
    bus_c4.start = 1'b0; bus_c4.a = '0; bus_c4.b = '0; bus_c4.cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset state", 64'({bus16.busy, bus16.done, bus16.s, bus16.cout, bus16.ovf}), 64'd0);
    rst = 1'b0;
    last_s16 = 16'h0000;
    @(negedge clk);

    run_op16("basic",   16'h1234, 16'h4321, 1'b0, -1);
    run_op16("ripple",  16'hFFFF, 16'h0000, 1'b1, -1);
    run_op16("posovf",  16'h7FFF, 16'h0001, 1'b0, -1);
    run_op16("negovf",  16'h8000, 16'h8000, 1'b0, -1);
    run_op16("ignore",  16'h0001, 16'h0001, 1'b0, 2);
    for (int i = 0; i < 6; i++) begin
      run_op16($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1'($urandom), -1);
    end

    // Reset lands on E2 of an op in flight.
    bus16.start = 1'b1; bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.cin = 1'b0;
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid outputs", 64'({bus16.busy, bus16.done, bus16.s, bus16.cout, bus16.ovf}), 64'd0);
    rst = 1'b0;
    last_s16 = 16'h0000;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus16.done) seen = 1'b1;
    end
    check("rst_mid no done", 64'(seen), 64'd0);
    run_op16("after_rst", 16'hBEEF, 16'h1001, 1'b1, -1);

    // start held high: accepts at edges 0,5,10,..; done at edges 4,9,14,..
    for (int t = 0; t < 30; t++) begin
      qa[t] = 16'($urandom);
      qb[t] = 16'($urandom);
      qc[t] = 1'($urandom);
    end
    dones = 0;
    bus16.start = 1'b1; bus16.a = qa[0]; bus16.b = qb[0]; bus16.cin = qc[0];
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      check($sformatf("b2b done t=%0d", t), 64'(bus16.done), 64'((t % 5) == 4));
      check($sformatf("b2b busy t=%0d", t), 64'(bus16.busy), 64'((t % 5) != 4));
      if (bus16.done) dones++;
      if ((t % 5) == 4) begin
        check($sformatf("b2b result t=%0d", t), 64'({bus16.cout, bus16.s, bus16.ovf}),
              64'(model16(qa[t-4], qb[t-4], qc[t-4])));
      end
      if (t < 29) begin
        bus16.a = qa[t+1]; bus16.b = qb[t+1]; bus16.cin = qc[t+1];
      end else begin
        bus16.start = 1'b0;
      end
    end
    check("b2b done count", 64'(dones), 64'd6);

    // Exhaustive 4-bit sweep over all three slice widths at once.
    for (int v = 0; v < 512; v++) begin
      logic [3:0] ea, eb;
      logic       ec;
      logic [5:0] e, r1, r2, r4;
      int         l1, l2, l4;
      ea = v[3:0];
      eb = v[7:4];
      ec = v[8];
      e  = model4(ea, eb, ec);
      bus_c1.start = 1'b1; bus_c1.a = ea; bus_c1.b = eb; bus_c1.cin = ec;
      bus_c2.start = 1'b1; bus_c2.a = ea; bus_c2.b = eb; bus_c2.cin = ec;
      bus_c4.start = 1'b1; bus_c4.a = ea; bus_c4.b = eb; bus_c4.cin = ec;
      @(negedge clk);
      bus_c1.start = 1'b0; bus_c2.start = 1'b0; bus_c4.start = 1'b0;
      l1 = 0; l2 = 0; l4 = 0;
      r1 = '0; r2 = '0; r4 = '0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (bus_c1.done && l1 == 0) begin l1 = k; r1 = {bus_c1.cout, bus_c1.s, bus_c1.ovf}; end
        if (bus_c2.done && l2 == 0) begin l2 = k; r2 = {bus_c2.cout, bus_c2.s, bus_c2.ovf}; end
        if (bus_c4.done && l4 == 0) begin l4 = k; r4 = {bus_c4.cout, bus_c4.s, bus_c4.ovf}; end
      end
      check($sformatf("x4c1 res v=%0d", v), 64'(r1), 64'(e));
      check($sformatf("x4c1 lat v=%0d", v), 64'(l1), 64'd4);
      check($sformatf("x4c2 res v=%0d", v), 64'(r2), 64'(e));
      check($sformatf("x4c2 lat v=%0d", v), 64'(l2), 64'd2);
      check($sformatf("x4c4 res v=%0d", v), 64'(r4), 64'(e));
      check($sformatf("x4c4 lat v=%0d", v), 64'(l4), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
